// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Operation codes mirror the funct3 field of the M-extension encodings.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } muldiv_state_e;

    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

    function automatic logic is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the control unit / register file and the
// multiply/divide unit.
interface muldiv_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic               start;
    logic [2:0]         op;
    logic [D_WIDTH-1:0] rs1_val;
    logic [D_WIDTH-1:0] rs2_val;
    logic [A_WIDTH-1:0] rd_in;
    logic               kill;
    logic               busy;
    logic               done;
    logic [D_WIDTH-1:0] result;
    logic [A_WIDTH-1:0] rd_out;
    logic               we;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in, kill,
        input  busy, done, result, rd_out, we
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in, kill,
        output busy, done, result, rd_out, we
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sharing one adder and shift register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(D_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(D_WIDTH - 1);
    localparam logic [D_WIDTH-1:0] ALL_ONES_W =
        (D_WIDTH == 32) ? D_WIDTH'(DIV_ALL_ONES) : {D_WIDTH{1'b1}};
    localparam logic [D_WIDTH-1:0] INT_MIN_W =
        (D_WIDTH == 32) ? D_WIDTH'(INT_MIN) : {1'b1, {(D_WIDTH-1){1'b0}}};

    muldiv_state_e          state_reg, state_next;
    logic [CW-1:0]          count_reg, count_next;
    muldiv_op_e             op_reg, op_next;
    logic [2*D_WIDTH-1:0]   prod_reg, prod_next;
    logic [D_WIDTH-1:0]     mag_b_reg, mag_b_next;
    logic                   neg_q_reg, neg_q_next;
    logic                   neg_r_reg, neg_r_next;
    logic [D_WIDTH-1:0]     result_reg, result_next;
    logic [A_WIDTH-1:0]     rd_reg, rd_next;

    // Request decode: signedness per operand, magnitudes and fast-path detection.
    muldiv_op_e             op_in;
    logic                   sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
    logic [D_WIDTH-1:0]     mag_a_in, mag_b_in;
    logic                   div_zero_in, div_ovf_in;

    assign op_in = muldiv_op_e'(bus.op);

    always_comb begin
        sgn_a_in    = is_div(op_in) ? !bus.op[0] : (op_in != OP_MULHU);
        sgn_b_in    = is_div(op_in) ? !bus.op[0] : (op_in == OP_MUL || op_in == OP_MULH);
        neg_a_in    = sgn_a_in && bus.rs1_val[D_WIDTH-1];
        neg_b_in    = sgn_b_in && bus.rs2_val[D_WIDTH-1];
        mag_a_in    = neg_a_in ? -bus.rs1_val : bus.rs1_val;
        mag_b_in    = neg_b_in ? -bus.rs2_val : bus.rs2_val;
        div_zero_in = is_div(op_in) && (bus.rs2_val == '0);
        div_ovf_in  = (op_in == OP_DIV || op_in == OP_REM) &&
                      (bus.rs1_val == INT_MIN_W) && (bus.rs2_val == ALL_ONES_W);
    end

    // One iteration step. prod_reg holds {acc, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [D_WIDTH-1:0]     hi, lo;
    logic                   sub;
    logic [D_WIDTH:0]       add_a, add_b, add_res;
    logic [2*D_WIDTH-1:0]   step, mul_full;
    logic [D_WIDTH-1:0]     quo, rem, fin;

    assign hi  = prod_reg[2*D_WIDTH-1:D_WIDTH];
    assign lo  = prod_reg[D_WIDTH-1:0];
    assign sub = is_div(op_reg);

    always_comb begin
        add_b   = {1'b0, mag_b_reg};
        add_a   = sub ? {hi, lo[D_WIDTH-1]} : {1'b0, hi};
        add_res = add_a + (sub ? ~add_b : add_b) + {{D_WIDTH{1'b0}}, sub};
        if (sub) begin
            // Bit D_WIDTH of the trial difference is the borrow: restore on borrow.
            step = add_res[D_WIDTH] ? {prod_reg[2*D_WIDTH-2:0], 1'b0}
                                    : {add_res[D_WIDTH-1:0], lo[D_WIDTH-2:0], 1'b1};
        end else begin
            step = lo[0] ? {add_res, lo[D_WIDTH-1:1]}
                         : {1'b0, prod_reg[2*D_WIDTH-1:1]};
        end
    end

    always_comb begin
        mul_full = neg_q_reg ? -step : step;
        quo      = neg_q_reg ? -step[D_WIDTH-1:0] : step[D_WIDTH-1:0];
        rem      = neg_r_reg ? -step[2*D_WIDTH-1:D_WIDTH] : step[2*D_WIDTH-1:D_WIDTH];
        unique case (op_reg)
            OP_MUL:                      fin = mul_full[D_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin = mul_full[2*D_WIDTH-1:D_WIDTH];
            OP_DIV, OP_DIVU:             fin = quo;
            default:                     fin = rem;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        op_next     = op_reg;
        prod_next   = prod_reg;
        mag_b_next  = mag_b_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;
        rd_next     = rd_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_next    = op_in;
                    rd_next    = bus.rd_in;
                    count_next = '0;
                    prod_next  = {{D_WIDTH{1'b0}}, mag_a_in};
                    mag_b_next = mag_b_in;
                    neg_q_next = neg_a_in ^ neg_b_in;
                    neg_r_next = neg_a_in;
                    if (div_zero_in) begin
                        result_next = is_rem(op_in) ? bus.rs1_val : ALL_ONES_W;
                        state_next  = ST_DONE;
                    end else if (div_ovf_in) begin
                        result_next = is_rem(op_in) ? '0 : INT_MIN_W;
                        state_next  = ST_DONE;
                    end else begin
                        state_next  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.kill) begin
                    state_next = ST_IDLE;
                end else begin
                    prod_next  = step;
                    count_next = count_reg + 1'b1;
                    if (count_reg == LAST_COUNT) begin
                        count_next  = '0;
                        result_next = fin;
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            op_reg     <= OP_MUL;
            prod_reg   <= '0;
            mag_b_reg  <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            rd_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
            prod_reg   <= prod_next;
            mag_b_reg  <= mag_b_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
            rd_reg     <= rd_next;
        end
    end

    // A kill landing in the DONE cycle must also hide that cycle's write.
    assign bus.busy   = (state_reg != ST_IDLE);
    assign bus.done   = (state_reg == ST_DONE) && !bus.kill;
    assign bus.we     = bus.done && (rd_reg != '0);
    assign bus.result = result_reg;
    assign bus.rd_out = rd_reg;

endmodule
